// File: rtl/pipeline_mem_arbiter_if.sv
// Signal bundle between the IF/MEM pipeline stages, the arbiter and the MIO memory bus.
// master = arbiter side, slave = pipeline stages plus memory side.
interface pipeline_mem_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_done;
   logic        if_stall;
   logic        if_err;

   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_done;
   logic        mem_stall;
   logic        mem_err;

   logic        bus_req;
   logic        bus_we;
   logic [3:0]  bus_be;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ready;

   modport master (
      input  if_req, if_addr, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
             bus_rdata, bus_ready,
      output if_rdata, if_done, if_stall, if_err,
             mem_rdata, mem_done, mem_stall, mem_err,
             bus_req, bus_we, bus_be, bus_addr, bus_wdata
   );

   modport slave (
      output if_req, if_addr, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
             bus_rdata, bus_ready,
      input  if_rdata, if_done, if_stall, if_err,
             mem_rdata, mem_done, mem_stall, mem_err,
             bus_req, bus_we, bus_be, bus_addr, bus_wdata
   );
endinterface

// File: rtl/pipeline_mem_arbiter.sv
// Shares the single-port MIO bus between IF and MEM; MEM has priority, bounded by a streak counter.
// Optional bus watchdog enabled by defining ARB_TIMEOUT_EN.
module pipeline_mem_arbiter #(
   parameter int MAX_MEM_STREAK = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                   clk,
   input  logic                   rst,
   pipeline_mem_arbiter_if.master arb
);
   localparam int SW = $clog2(MAX_MEM_STREAK + 1);

   typedef enum logic [1:0] {IDLE, IF_BUS, MEM_BUS, RESP} state_t;

   state_t        state_reg, state_next;
   logic [SW-1:0] streak_reg;
   logic          grant_if, grant_mem, bus_done, bus_abort, timeout_hit;

   logic          bus_req_reg, bus_we_reg;
   logic [3:0]    bus_be_reg;
   logic [31:0]   bus_addr_reg, bus_wdata_reg;
   logic [31:0]   if_rdata_reg, mem_rdata_reg;
   logic          if_done_reg, mem_done_reg, if_err_reg, mem_err_reg;

   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      grant_if   = 1'b0;
      grant_mem  = 1'b0;
      bus_done   = 1'b0;
      bus_abort  = 1'b0;
      case (state_reg)
         IDLE: begin
            // IF is forced in once MEM has used up its streak while IF waited
            if (arb.mem_req && !(arb.if_req && streak_reg == SW'(MAX_MEM_STREAK)))
               grant_mem = 1'b1;
            else if (arb.if_req)
               grant_if = 1'b1;
            if (grant_mem)     state_next = MEM_BUS;
            else if (grant_if) state_next = IF_BUS;
         end
         IF_BUS, MEM_BUS: begin
            if (arb.bus_ready)    bus_done  = 1'b1;
            else if (timeout_hit) bus_abort = 1'b1;
            if (bus_done || bus_abort) state_next = RESP;
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

`ifdef ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] wait_reg;

   always_ff @(posedge clk) begin
      if (rst || grant_if || grant_mem)
         wait_reg <= '0;
      else if (state_reg == IF_BUS || state_reg == MEM_BUS)
         wait_reg <= wait_reg + TW'(1);
   end

   // The current BUS cycle is the last permitted wait cycle
   assign timeout_hit = (wait_reg == TW'(TIMEOUT_CYCLES - 1));
   assign arb.if_err  = if_err_reg;
   assign arb.mem_err = mem_err_reg;
`else
   assign timeout_hit = 1'b0;
   assign arb.if_err  = 1'b0;
   assign arb.mem_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         streak_reg    <= '0;
         bus_req_reg   <= 1'b0;
         bus_we_reg    <= 1'b0;
         bus_be_reg    <= 4'h0;
         bus_addr_reg  <= 32'h0;
         bus_wdata_reg <= 32'h0;
         if_rdata_reg  <= 32'h0;
         mem_rdata_reg <= 32'h0;
         if_done_reg   <= 1'b0;
         mem_done_reg  <= 1'b0;
         if_err_reg    <= 1'b0;
         mem_err_reg   <= 1'b0;
      end else begin
         if_done_reg  <= 1'b0;
         mem_done_reg <= 1'b0;
         if_err_reg   <= 1'b0;
         mem_err_reg  <= 1'b0;
         if (grant_if) begin
            bus_req_reg   <= 1'b1;
            bus_we_reg    <= 1'b0;
            bus_be_reg    <= 4'hF;
            bus_addr_reg  <= arb.if_addr;
            bus_wdata_reg <= 32'h0;
            streak_reg    <= '0;
         end
         if (grant_mem) begin
            bus_req_reg   <= 1'b1;
            bus_we_reg    <= arb.mem_we;
            bus_be_reg    <= arb.mem_be;
            bus_addr_reg  <= arb.mem_addr;
            bus_wdata_reg <= arb.mem_wdata;
            if (!arb.if_req)
               streak_reg <= '0;
            else if (streak_reg != SW'(MAX_MEM_STREAK))
               streak_reg <= streak_reg + SW'(1);
         end
         if (bus_done || bus_abort) begin
            bus_req_reg <= 1'b0;
            if (state_reg == MEM_BUS) begin
               mem_done_reg <= 1'b1;
               mem_err_reg  <= bus_abort;
               // a completed store leaves the load data register untouched
               if (bus_abort)        mem_rdata_reg <= 32'h0;
               else if (!bus_we_reg) mem_rdata_reg <= arb.bus_rdata;
            end else begin
               if_done_reg  <= 1'b1;
               if_err_reg   <= bus_abort;
               if_rdata_reg <= bus_abort ? 32'h0 : arb.bus_rdata;
            end
         end
      end
   end

   assign arb.bus_req   = bus_req_reg;
   assign arb.bus_we    = bus_we_reg;
   assign arb.bus_be    = bus_be_reg;
   assign arb.bus_addr  = bus_addr_reg;
   assign arb.bus_wdata = bus_wdata_reg;
   assign arb.if_rdata  = if_rdata_reg;
   assign arb.mem_rdata = mem_rdata_reg;
   assign arb.if_done   = if_done_reg;
   assign arb.mem_done  = mem_done_reg;
   assign arb.if_stall  = arb.if_req && !if_done_reg;
   assign arb.mem_stall = arb.mem_req && !mem_done_reg;
endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Directed testbench for pipeline_mem_arbiter; timeout expectations depend on ARB_TIMEOUT_EN.
module tb_pipeline_mem_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   pipeline_mem_arbiter_if arb_if ();

   pipeline_mem_arbiter #(.MAX_MEM_STREAK(4), .TIMEOUT_CYCLES(8)) dut (
      .clk (clk),
      .rst (rst),
      .arb (arb_if)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout observed=no_finish expected=finish");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      logic [31:0] exp_addr [6];
      exp_addr = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h100, 32'h200};

      arb_if.if_req    = 1'b0;
      arb_if.if_addr   = 32'h0;
      arb_if.mem_req   = 1'b0;
      arb_if.mem_we    = 1'b0;
      arb_if.mem_be    = 4'h0;
      arb_if.mem_addr  = 32'h0;
      arb_if.mem_wdata = 32'h0;
      arb_if.bus_rdata = 32'h0;
      arb_if.bus_ready = 1'b0;

      // reset state
      step(); step(); step();
      check("rst_bus_req",   {31'h0, arb_if.bus_req},   32'h0);
      check("rst_bus_addr",  arb_if.bus_addr,           32'h0);
      check("rst_bus_be",    {28'h0, arb_if.bus_be},    32'h0);
      check("rst_if_rdata",  arb_if.if_rdata,           32'h0);
      check("rst_mem_rdata", arb_if.mem_rdata,          32'h0);
      check("rst_if_done",   {31'h0, arb_if.if_done},   32'h0);
      check("rst_mem_done",  {31'h0, arb_if.mem_done},  32'h0);
      check("rst_mem_err",   {31'h0, arb_if.mem_err},   32'h0);
      check("rst_if_stall",  {31'h0, arb_if.if_stall},  32'h0);
      rst = 1'b0;
      step();

      // single fetch, zero-wait bus
      arb_if.if_req  = 1'b1;
      arb_if.if_addr = 32'h0000_0040;
      #1;
      check("fetch_stall_c1", {31'h0, arb_if.if_stall}, 32'h1);
      step();
      check("fetch_bus_req",  {31'h0, arb_if.bus_req},  32'h1);
      check("fetch_bus_addr", arb_if.bus_addr,          32'h0000_0040);
      check("fetch_bus_we",   {31'h0, arb_if.bus_we},   32'h0);
      check("fetch_bus_be",   {28'h0, arb_if.bus_be},   32'hF);
      check("fetch_stall_c2", {31'h0, arb_if.if_stall}, 32'h1);
      check("fetch_done_c2",  {31'h0, arb_if.if_done},  32'h0);
      arb_if.bus_ready = 1'b1;
      arb_if.bus_rdata = 32'h2008_0005;
      step();
      check("fetch_done",     {31'h0, arb_if.if_done},  32'h1);
      check("fetch_rdata",    arb_if.if_rdata,          32'h2008_0005);
      check("fetch_stall_c3", {31'h0, arb_if.if_stall}, 32'h0);
      check("fetch_bus_drop", {31'h0, arb_if.bus_req},  32'h0);
      arb_if.if_req    = 1'b0;
      arb_if.bus_ready = 1'b0;
      step();
      check("fetch_done_off", {31'h0, arb_if.if_done},  32'h0);
      check("fetch_rdata_hold", arb_if.if_rdata,        32'h2008_0005);

      // store with two wait cycles
      arb_if.mem_req   = 1'b1;
      arb_if.mem_we    = 1'b1;
      arb_if.mem_be    = 4'b0011;
      arb_if.mem_addr  = 32'h10;
      arb_if.mem_wdata = 32'hDEAD_BEEF;
      arb_if.bus_rdata = 32'h1234_5678;
      step();
      for (int c = 0; c < 3; c++) begin
         check($sformatf("store_bus_req_c%0d", c),   {31'h0, arb_if.bus_req},  32'h1);
         check($sformatf("store_bus_we_c%0d", c),    {31'h0, arb_if.bus_we},   32'h1);
         check($sformatf("store_bus_be_c%0d", c),    {28'h0, arb_if.bus_be},   32'h3);
         check($sformatf("store_bus_addr_c%0d", c),  arb_if.bus_addr,          32'h10);
         check($sformatf("store_bus_wdata_c%0d", c), arb_if.bus_wdata,         32'hDEAD_BEEF);
         check($sformatf("store_done_c%0d", c),      {31'h0, arb_if.mem_done}, 32'h0);
         arb_if.mem_wdata = 32'h0BAD_0BAD;
         if (c == 2) arb_if.bus_ready = 1'b1;
         step();
      end
      check("store_done",       {31'h0, arb_if.mem_done}, 32'h1);
      check("store_rdata_keep", arb_if.mem_rdata,         32'h0);
      arb_if.mem_req   = 1'b0;
      arb_if.mem_we    = 1'b0;
      arb_if.bus_ready = 1'b0;
      step();
      check("store_done_off", {31'h0, arb_if.mem_done}, 32'h0);

      // contention: MEM x4 then IF, then MEM again
      arb_if.if_req    = 1'b1;
      arb_if.if_addr   = 32'h100;
      arb_if.mem_req   = 1'b1;
      arb_if.mem_be    = 4'hF;
      arb_if.mem_addr  = 32'h200;
      arb_if.bus_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         arb_if.bus_rdata = 32'hA000_0000 + k;
         step();
         check($sformatf("cont_grant%0d_addr", k), arb_if.bus_addr, exp_addr[k]);
         if (exp_addr[k] == 32'h100)
            check("cont_streak_clear", 32'(dut.streak_reg), 32'h0);
         step();
         if (exp_addr[k] == 32'h100) begin
            check($sformatf("cont_grant%0d_if_done", k), {31'h0, arb_if.if_done},  32'h1);
            check($sformatf("cont_grant%0d_mem_done", k), {31'h0, arb_if.mem_done}, 32'h0);
            check($sformatf("cont_grant%0d_if_rdata", k), arb_if.if_rdata,          32'hA000_0000 + k);
         end else begin
            check($sformatf("cont_grant%0d_mem_done", k), {31'h0, arb_if.mem_done}, 32'h1);
            check($sformatf("cont_grant%0d_if_done", k),  {31'h0, arb_if.if_done},  32'h0);
            check($sformatf("cont_grant%0d_mem_rdata", k), arb_if.mem_rdata,        32'hA000_0000 + k);
         end
         if (k == 5) begin
            arb_if.if_req  = 1'b0;
            arb_if.mem_req = 1'b0;
         end
         step();
      end

      // back-to-back fetches at PC 0, 4, 8
      arb_if.if_req = 1'b1;
      for (int p = 0; p < 3; p++) begin
         arb_if.if_addr   = 32'(p * 4);
         arb_if.bus_rdata = 32'h1000_0000 | 32'(p * 4);
         step();
         check($sformatf("b2b%0d_addr", p), arb_if.bus_addr, 32'(p * 4));
         check($sformatf("b2b%0d_done_early", p), {31'h0, arb_if.if_done}, 32'h0);
         step();
         check($sformatf("b2b%0d_done", p),  {31'h0, arb_if.if_done}, 32'h1);
         check($sformatf("b2b%0d_rdata", p), arb_if.if_rdata, 32'h1000_0000 | 32'(p * 4));
         if (p == 2) arb_if.if_req = 1'b0;
         step();
         check($sformatf("b2b%0d_done_off", p), {31'h0, arb_if.if_done}, 32'h0);
      end

      // reset during MEM_BUS
      arb_if.bus_ready = 1'b0;
      arb_if.mem_req   = 1'b1;
      arb_if.mem_addr  = 32'h30;
      step();
      check("rstop_bus_req",  {31'h0, arb_if.bus_req}, 32'h1);
      check("rstop_bus_addr", arb_if.bus_addr,         32'h30);
      rst            = 1'b1;
      arb_if.mem_req = 1'b0;
      step();
      check("rstop_bus_req_off", {31'h0, arb_if.bus_req},  32'h0);
      check("rstop_no_done",     {31'h0, arb_if.mem_done}, 32'h0);
      check("rstop_rdata_clr",   arb_if.mem_rdata,         32'h0);
      rst              = 1'b0;
      arb_if.bus_ready = 1'b1;
      arb_if.bus_rdata = 32'hCAFE_F00D;
      step();
      check("rstop_late_ready_done", {31'h0, arb_if.mem_done}, 32'h0);
      check("rstop_late_ready_req",  {31'h0, arb_if.bus_req},  32'h0);
      step();
      check("rstop_late_ready_done2", {31'h0, arb_if.mem_done}, 32'h0);
      check("rstop_late_ready_rdata", arb_if.mem_rdata,         32'h0);

      // load to give mem_rdata a nonzero value
      arb_if.mem_req   = 1'b1;
      arb_if.mem_addr  = 32'h44;
      arb_if.bus_rdata = 32'h55AA_55AA;
      step();
      step();
      check("load_done",  {31'h0, arb_if.mem_done}, 32'h1);
      check("load_rdata", arb_if.mem_rdata,         32'h55AA_55AA);
      check("load_err",   {31'h0, arb_if.mem_err},  32'h0);
      arb_if.mem_req = 1'b0;
      step();

      // bus never answers
      arb_if.bus_ready = 1'b0;
      arb_if.bus_rdata = 32'hFFFF_FFFF;
      arb_if.mem_req   = 1'b1;
      arb_if.mem_addr  = 32'h48;
      step();
`ifdef ARB_TIMEOUT_EN
      for (int w = 0; w < 8; w++) begin
         check($sformatf("tmo_wait%0d_done", w), {31'h0, arb_if.mem_done}, 32'h0);
         check($sformatf("tmo_wait%0d_req", w),  {31'h0, arb_if.bus_req},  32'h1);
         step();
      end
      check("tmo_done",    {31'h0, arb_if.mem_done}, 32'h1);
      check("tmo_err",     {31'h0, arb_if.mem_err},  32'h1);
      check("tmo_rdata",   arb_if.mem_rdata,         32'h0);
      check("tmo_bus_req", {31'h0, arb_if.bus_req},  32'h0);
      check("tmo_if_err",  {31'h0, arb_if.if_err},   32'h0);
      arb_if.mem_req = 1'b0;
      step();
      check("tmo_err_off", {31'h0, arb_if.mem_err}, 32'h0);
`else
      for (int w = 0; w < 12; w++) begin
         check($sformatf("hang%0d_stall", w), {31'h0, arb_if.mem_stall}, 32'h1);
         check($sformatf("hang%0d_done", w),  {31'h0, arb_if.mem_done},  32'h0);
         check($sformatf("hang%0d_err", w),   {31'h0, arb_if.mem_err},   32'h0);
         step();
      end
      check("hang_rdata_hold", arb_if.mem_rdata, 32'h55AA_55AA);
      rst            = 1'b1;
      arb_if.mem_req = 1'b0;
      step();
      rst = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
